// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read RAM between the pipeline memory stage and a
// debug/loader port, with bounded debug starvation and per-requester read-data return.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_p_req,
  input  logic                  i_p_we,
  input  logic [31:0]           i_p_addr,
  input  logic [DATA_W-1:0]     i_p_wdata,
  input  logic [DATA_W/8-1:0]   i_p_be,
  output logic                  o_p_gnt,
  output logic                  o_p_rvalid,
  output logic [DATA_W-1:0]     o_p_rdata,
  output logic                  o_stall,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [31:0]           i_d_addr,
  input  logic [DATA_W-1:0]     i_d_wdata,
  input  logic                  i_d_halt,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_W-1:0]     o_d_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_be,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int unsigned BeW = DATA_W / 8;

  logic [3:0]        starve_q, starve_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_own_q, rd_own_d;
  logic [DATA_W-1:0] p_hold_q, p_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;
  logic              starved;
  logic              unused_addr;

  assign starved = (starve_q == 4'(STARVE_MAX));

  // Byte-offset and high address bits alias silently onto the RAM.
  assign unused_addr = ^{i_p_addr[31:ADDR_W+2], i_p_addr[1:0],
                         i_d_addr[31:ADDR_W+2], i_d_addr[1:0]};

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    o_d_gnt = 1'b0;
    o_p_gnt = 1'b0;
    if (!i_rst) begin
      if (i_d_halt) begin
        o_d_gnt = i_d_req;
      end else if (i_p_req && i_d_req) begin
        o_d_gnt = starved;
        o_p_gnt = !starved;
      end else begin
        o_d_gnt = i_d_req;
        o_p_gnt = i_p_req;
      end
    end
  end

  assign o_stall = i_p_req & ~o_p_gnt;

  always_comb begin
    o_mem_en    = o_p_gnt | o_d_gnt;
    o_mem_we    = (o_p_gnt & i_p_we) | (o_d_gnt & i_d_we);
    o_mem_addr  = o_d_gnt ? i_d_addr[ADDR_W+1:2] : i_p_addr[ADDR_W+1:2];
    o_mem_wdata = o_d_gnt ? i_d_wdata : i_p_wdata;
    o_mem_be    = '0;
    if (o_p_gnt) begin
      o_mem_be = i_p_be;
    end else if (o_d_gnt) begin
      o_mem_be = {BeW{1'b1}};
    end
  end

  // Read return: the owner sees live RAM data, the other side keeps its last word.
  always_comb begin
    o_p_rvalid = ~i_rst & rd_pend_q & ~rd_own_q;
    o_d_rvalid = ~i_rst & rd_pend_q & rd_own_q;
    p_hold_d   = o_p_rvalid ? i_mem_rdata : p_hold_q;
    d_hold_d   = o_d_rvalid ? i_mem_rdata : d_hold_q;
    o_p_rdata  = i_rst ? '0 : p_hold_d;
    o_d_rdata  = i_rst ? '0 : d_hold_d;
  end

  always_comb begin
    rd_pend_d = (o_p_gnt & ~i_p_we) | (o_d_gnt & ~i_d_we);
    rd_own_d  = o_d_gnt;
    starve_d  = starve_q;
    if (i_d_req && o_p_gnt) begin
      if (!starved) begin
        starve_d = starve_q + 4'd1;
      end
    end else if (o_d_gnt || !i_d_req) begin
      starve_d = 4'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_q  <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
      p_hold_q  <= '0;
      d_hold_q  <= '0;
    end else begin
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
      p_hold_q  <= p_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of grants, memory image and read return.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned WORDS      = 1 << ADDR_W;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_p_req = 0, i_p_we = 0, i_d_req = 0, i_d_we = 0, i_d_halt = 0;
  logic [31:0] i_p_addr = 0, i_d_addr = 0, i_p_wdata = 0, i_d_wdata = 0;
  logic [3:0]  i_p_be = 0;
  logic        o_p_gnt, o_p_rvalid, o_stall, o_d_gnt, o_d_rvalid, o_mem_en, o_mem_we;
  logic [31:0] o_p_rdata, o_d_rdata, o_mem_wdata;
  logic [7:0]  o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] i_mem_rdata = 0;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_p_req(i_p_req), .i_p_we(i_p_we), .i_p_addr(i_p_addr), .i_p_wdata(i_p_wdata),
    .i_p_be(i_p_be), .o_p_gnt(o_p_gnt), .o_p_rvalid(o_p_rvalid), .o_p_rdata(o_p_rdata),
    .o_stall(o_stall), .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_halt(i_d_halt), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid),
    .o_d_rdata(o_d_rdata), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural RAM attached to the DUT memory port.
  logic [31:0] ram [WORDS];
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++) if (o_mem_be[b]) ram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end else begin
        i_mem_rdata <= ram[o_mem_addr];
      end
    end
  end

  // Reference model state.
  logic [31:0] mmem [WORDS];
  int          m_starve = 0;
  bit          m_pend = 0, m_own = 0;
  logic [31:0] m_pdata = 0, m_phold = 0, m_dhold = 0;

  always @(negedge i_clk) begin : cmp
    bit          eg_p, eg_d, ep_rv, ed_rv, e_we;
    int          w;
    logic [31:0] e_prd, e_drd, wd;
    logic [3:0]  be;
    if (i_rst) begin
      eg_p = 0; eg_d = 0;
    end else if (i_d_halt) begin
      eg_p = 0; eg_d = i_d_req;
    end else if (i_p_req && i_d_req) begin
      eg_d = (m_starve == STARVE_MAX); eg_p = !eg_d;
    end else begin
      eg_p = i_p_req; eg_d = i_d_req;
    end
    ep_rv = !i_rst && m_pend && !m_own;
    ed_rv = !i_rst && m_pend && m_own;
    e_prd = i_rst ? 32'h0 : (ep_rv ? m_pdata : m_phold);
    e_drd = i_rst ? 32'h0 : (ed_rv ? m_pdata : m_dhold);
    w     = eg_d ? int'(i_d_addr[ADDR_W+1:2]) : int'(i_p_addr[ADDR_W+1:2]);
    e_we  = eg_d ? i_d_we : i_p_we;
    wd    = eg_d ? i_d_wdata : i_p_wdata;
    be    = eg_d ? 4'hF : i_p_be;

    chk("p_gnt", o_p_gnt, eg_p);
    chk("d_gnt", o_d_gnt, eg_d);
    chk("stall", o_stall, i_p_req && !eg_p);
    chk("p_rvalid", o_p_rvalid, ep_rv);
    chk("d_rvalid", o_d_rvalid, ed_rv);
    chk("p_rdata", o_p_rdata, e_prd);
    chk("d_rdata", o_d_rdata, e_drd);
    chk("mem_en", o_mem_en, eg_p || eg_d);
    if (eg_p || eg_d) begin
      chk("mem_addr", o_mem_addr, w);
      chk("mem_we", o_mem_we, e_we);
      chk("mem_be", o_mem_be, be);
      if (e_we) chk("mem_wdata", o_mem_wdata, wd);
    end else begin
      chk("mem_we_idle", o_mem_we, 0);
      chk("mem_be_idle", o_mem_be, 0);
    end

    if (i_rst) begin
      m_starve = 0; m_pend = 0; m_phold = 0; m_dhold = 0;
    end else begin
      m_phold = e_prd;
      m_dhold = e_drd;
      m_pend  = (eg_p || eg_d) && !e_we;
      m_own   = eg_d;
      if (m_pend) m_pdata = mmem[w];
      if ((eg_p || eg_d) && e_we)
        for (int b = 0; b < 4; b++) if (be[b]) mmem[w][8*b +: 8] = wd[8*b +: 8];
      if (i_d_req && eg_p) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else if (eg_d || !i_d_req) m_starve = 0;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pset(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    i_p_req = req; i_p_we = we; i_p_addr = a; i_p_wdata = d; i_p_be = be;
  endtask

  task automatic dset(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    i_d_req = req; i_d_we = we; i_d_addr = a; i_d_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin ram[i] = 0; mmem[i] = 0; end
    #1;
    pset(1, 0, 32'h10, 0, 4'hF);
    step();
    chk("lit_rst_stall", o_stall, 1);
    chk("lit_rst_pgnt", o_p_gnt, 0);
    chk("lit_rst_memen", o_mem_en, 0);
    step();
    i_rst = 0;

    // Full-word write then read back.
    pset(1, 1, 32'h10, 32'hDEADBEEF, 4'hF); #1; chk("lit_wr_gnt", o_p_gnt, 1); step();
    pset(1, 0, 32'h10, 0, 4'hF);            #1; chk("lit_rd_gnt", o_p_gnt, 1); step();
    pset(0, 0, 0, 0, 0); #1;
    chk("lit_rd_rvalid", o_p_rvalid, 1);
    chk("lit_rd_data", o_p_rdata, 32'hDEADBEEF);
    chk("lit_rd_drvalid", o_d_rvalid, 0);
    step();

    // Byte-lane merge.
    pset(1, 1, 32'h20, 32'h11223344, 4'hF); step();
    pset(1, 1, 32'h20, 32'h0000AB00, 4'b0010); step();
    pset(1, 0, 32'h20, 0, 4'hF); step();
    pset(0, 0, 0, 0, 0); #1;
    chk("lit_sb_data", o_p_rdata, 32'h1122AB44);
    step();

    // Continuous contention: pppp d repeating.
    pset(1, 0, 32'h40, 0, 4'hF); dset(1, 0, 32'h44, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("lit_starve_pgnt", o_p_gnt, (i % 5) != 4);
      chk("lit_starve_dgnt", o_d_gnt, (i % 5) == 4);
      chk("lit_starve_stall", o_stall, (i % 5) == 4);
      step();
    end

    // Halt: debug owns the memory.
    i_d_halt = 1; dset(1, 1, 32'h0, 32'h00000013); pset(1, 0, 32'h0, 0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_halt_pgnt", o_p_gnt, 0);
      chk("lit_halt_stall", o_stall, 1);
      chk("lit_halt_dgnt", o_d_gnt, 1);
      step();
    end
    i_d_halt = 0; dset(0, 0, 0, 0); step();
    pset(0, 0, 0, 0, 0); #1;
    chk("lit_halt_rd", o_p_rdata, 32'h00000013);
    step();

    // Interleaved reads.
    dset(1, 1, 32'h4, 32'hA5A50004); step();
    dset(1, 1, 32'h8, 32'h5A5A0008); step();
    dset(0, 0, 0, 0); pset(1, 0, 32'h4, 0, 4'hF); step();
    pset(0, 0, 0, 0, 0); dset(1, 0, 32'h8, 0); #1;
    chk("lit_il_prv", o_p_rvalid, 1);
    chk("lit_il_pdata", o_p_rdata, 32'hA5A50004);
    step();
    dset(0, 0, 0, 0); #1;
    chk("lit_il_drv", o_d_rvalid, 1);
    chk("lit_il_ddata", o_d_rdata, 32'h5A5A0008);
    chk("lit_il_pprv", o_p_rvalid, 0);
    step();

    // Reset discards an in-flight read.
    pset(1, 0, 32'h10, 0, 4'hF); step();
    pset(0, 0, 0, 0, 0); i_rst = 1; #1;
    chk("lit_rst_rv", o_p_rvalid, 0);
    step();
    i_rst = 0; #1;
    chk("lit_post_rst_rv", o_p_rvalid, 0);
    step();
    pset(1, 0, 32'h10, 0, 4'hF); dset(1, 0, 32'h14, 0); #1;
    chk("lit_post_rst_pgnt", o_p_gnt, 1);
    chk("lit_post_rst_dgnt", o_d_gnt, 0);
    step();

    // Random traffic with aliasing addresses.
    for (int c = 0; c < 3000; c++) begin
      i_rst    = ($urandom_range(0, 99) == 0);
      i_d_halt = ($urandom_range(0, 7) == 0);
      pset($urandom_range(0, 9) < 7, $urandom_range(0, 1),
           ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 3),
           $urandom, 4'($urandom));
      dset($urandom_range(0, 9) < 4, $urandom_range(0, 1),
           ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 3),
           $urandom);
      step();
    end
    pset(0, 0, 0, 0, 0); dset(0, 0, 0, 0); i_rst = 0; i_d_halt = 0;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-ported data memory between the pipeline memory stage and a debug/program-loader port.
- Sequences one access per cycle onto a synchronous-read RAM with 1-cycle read latency.
- Routes read data back to whichever requester issued the read.
- Raises a pipeline stall when the pipeline loses arbitration.
- A bounded-starvation counter guarantees debug progress while the pipeline is saturating the memory.

Parameters:
ADDR_W, 8, word-address width of the RAM (2^ADDR_W words)
DATA_W, 32, data width; byte enables are DATA_W/8 bits
STARVE_MAX, 4, consecutive debug-losing cycles before debug is forced a win (range 1..15)

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
i_p_req  input  1  pipeline access request
i_p_we  input  1  pipeline write (1) / read (0)
i_p_addr  input  32  pipeline byte address; bits [ADDR_W+1:2] select the word
i_p_wdata  input  DATA_W  pipeline store data
i_p_be  input  DATA_W/8  pipeline store byte enables
o_p_gnt  output  1  pipeline request accepted this cycle
o_p_rvalid  output  1  pipeline read data valid
o_p_rdata  output  DATA_W  pipeline read data
o_stall  output  1  equals i_p_req & ~o_p_gnt
i_d_req  input  1  debug access request
i_d_we  input  1  debug write/read
i_d_addr  input  32  debug byte address
i_d_wdata  input  DATA_W  debug write data (always full word)
i_d_halt  input  1  while high, pipeline is never granted
o_d_gnt  output  1  debug request accepted this cycle
o_d_rvalid  output  1  debug read data valid
o_d_rdata  output  DATA_W  debug read data
o_mem_en  output  1  RAM access enable
o_mem_we  output  1  RAM write enable
o_mem_addr  output  ADDR_W  RAM word address
o_mem_wdata  output  DATA_W  RAM write data
o_mem_be  output  DATA_W/8  RAM byte enables
i_mem_rdata  input  DATA_W  RAM read data, valid the cycle after a read enable

Behaviour:
- Grants are combinational in the same cycle as the request. A request is accepted when req and gnt are both high. At most one gnt per cycle.
- Priority:
  - i_d_halt=1: debug wins whenever i_d_req=1; o_p_gnt=0.
  - Otherwise, if both request: pipeline wins unless starve_cnt==STARVE_MAX, in which case debug wins.
  - A single requester always wins.
- starve_cnt (4 bits, reset 0):
  - Increments when i_d_req=1 and the pipeline is granted.
  - Clears when debug is granted or i_d_req=0.
  - Saturates at STARVE_MAX.
- Memory drive:
  - o_mem_en = o_p_gnt | o_d_gnt.
  - addr/we/wdata/be are muxed from the winner.
  - Debug be = all ones.
  - With no grant: o_mem_we=0 and o_mem_be=0.
  - Upper address bits above ADDR_W+1 and bits [1:0] are ignored (wrap-around aliasing, no error).
- Read return:
  - On a read grant, owner registers rd_pend (1b) and rd_own (0=pipeline, 1=debug) are set.
  - Next cycle, the owner's rvalid=1 for exactly one cycle and its rdata=i_mem_rdata.
  - The non-owner's rdata holds its last value and its rvalid=0.
  - Back-to-back reads are fully pipelined: 1 access/cycle, 1-cycle latency.
- Writes: no rvalid. A read of the same word in the next cycle returns the written data.
- Read-during-stall: a pipeline read that is stalled issues nothing. It is granted later with normal 1-cycle latency.
- Reset (also mid-operation):
  - starve_cnt=0, rd_pend=0.
  - All rvalid, rdata=0.
  - Any read in flight is discarded (no rvalid after reset).
  - During reset, gnt outputs=0, o_mem_en=0, o_stall=i_p_req.

Test Plan:
- Pipeline write addr 0x10, wdata 0xDEADBEEF, be 4'hF, then read 0x10 next cycle -> o_p_gnt=1 both cycles; o_p_rvalid=1 in cycle 3 with rdata 0xDEADBEEF; o_d_rvalid=0.
- Pipeline sb-style write be=4'b0010, wdata 0x0000AB00 over 0x11223344 at 0x20, then read -> rdata 0x1122AB44.
- Both request continuously with STARVE_MAX=4 -> pipeline granted cycles 1-4, debug granted cycle 5; o_stall=1 only in cycle 5; pattern repeats.
- i_d_halt=1, debug writes 0x00000013 to 0x0, pipeline requesting -> o_p_gnt=0 and o_stall=1 every cycle; debug granted each cycle; after release, pipeline read of 0x0 returns 0x00000013.
- Interleaved reads: pipeline read 0x4, then debug read 0x8 on consecutive cycles -> o_p_rvalid in cycle 2, o_d_rvalid in cycle 3, each with its own word.
- Pipeline read granted, i_rst asserted the next cycle -> no o_p_rvalid; after release, starve_cnt=0 and the first dual request is won by the pipeline.
